sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_param.sv | 93 +++++++++
 tb/tb_sync_fifo_param.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered or first-word-fall-through read, occupancy count and status flags.
// Full rejects writes and empty rejects reads; wr_ack, overflow and underflow report the previous cycle's requests.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       wr_ack,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       full,
  output logic                       empty,
  output logic                       almostfull,
  output logic                       almostempty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (AE_THRESH < 0) || (AE_THRESH >= AF_THRESH) || (AF_THRESH > DEPTH)) begin : g_bad_params
    $error("sync_fifo_param: illegal DEPTH/threshold parameters");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_accept;
  logic                  rd_accept;

  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign almostfull  = (count >= AF_C);
  assign almostempty = (count <= AE_C);

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  // Storage is deliberately left out of reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      wr_ack    <= wr_accept;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is visible without a read; contents are meaningless while empty.
    assign data_out = mem[rd_ptr];
  end else begin : g_reg_read
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_out <= '0;
      end else if (rd_accept) begin
        data_out <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: registered-read FIFO through fill, drain, simultaneous access, wrap and async reset,
// plus a first-word-fall-through instance.
module tb_sync_fifo_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rd_en;
  logic [15:0] data_in, data_out;
  logic        wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
  logic [3:0]  count;

  logic        wr_en2, rd_en2;
  logic [15:0] data_in2, data_out2;
  logic        wr_ack2, overflow2, underflow2, full2, empty2, almostfull2, almostempty2;
  logic [3:0]  count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(16), .DEPTH(8), .FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
    .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty),
    .count(count)
  );

  sync_fifo_param #(.DATA_WIDTH(16), .DEPTH(8), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en2), .data_in(data_in2), .rd_en(rd_en2),
    .data_out(data_out2), .wr_ack(wr_ack2), .overflow(overflow2), .underflow(underflow2),
    .full(full2), .empty(empty2), .almostfull(almostfull2), .almostempty(almostempty2),
    .count(count2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    wr_en2 = 1'b0; rd_en2 = 1'b0; data_in2 = '0;
    step(); step();

    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almostempty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almostfull, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_data_out", data_out, 0);
    rst_n = 1'b1;
    step();

    // Fill
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; data_in = 16'(i);
      step();
      chk("fill_ack", wr_ack, 1);
      chk("fill_count", count, 32'(i));
      chk("fill_afull", almostfull, (i >= 7) ? 1 : 0);
      chk("fill_full", full, (i == 8) ? 1 : 0);
    end
    data_in = 16'h0009;
    step();
    chk("ovf_flag", overflow, 1);
    chk("ovf_ack", wr_ack, 0);
    chk("ovf_count", count, 8);
    wr_en = 1'b0;
    step();
    chk("ovf_clear", overflow, 0);

    // Drain
    for (int i = 1; i <= 8; i++) begin
      rd_en = 1'b1;
      step();
      chk("drain_data", data_out, 32'(i));
      chk("drain_count", count, 32'(8 - i));
      chk("drain_aempty", almostempty, ((8 - i) <= 1) ? 1 : 0);
    end
    step();
    chk("udf_flag", underflow, 1);
    chk("udf_hold", data_out, 16'h0008);
    chk("udf_count", count, 0);
    rd_en = 1'b0;
    step();
    chk("udf_clear", underflow, 0);

    // Simultaneous at count=4
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; data_in = 16'h0010 + 16'(i);
      step();
    end
    rd_en = 1'b1; data_in = 16'h0014;
    step();
    wr_en = 1'b0;
    chk("sim4_count", count, 4);
    chk("sim4_data", data_out, 16'h0010);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("sim4_order", data_out, 16'h0010 + 16'(i));
    end
    rd_en = 1'b0;
    chk("sim4_empty", empty, 1);

    // Simultaneous when full
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; data_in = 16'h0020 + 16'(i);
      step();
    end
    rd_en = 1'b1; data_in = 16'h0099;
    step();
    wr_en = 1'b0;
    chk("simf_overflow", overflow, 1);
    chk("simf_ack", wr_ack, 0);
    chk("simf_count", count, 7);
    chk("simf_data", data_out, 16'h0020);
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("simf_order", data_out, 16'h0020 + 16'(i));
    end
    rd_en = 1'b0;

    // Simultaneous when empty
    wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h0055;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("sime_underflow", underflow, 1);
    chk("sime_ack", wr_ack, 1);
    chk("sime_count", count, 1);
    chk("sime_hold", data_out, 16'h0027);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("sime_data", data_out, 16'h0055);
    chk("sime_empty", empty, 1);

    // Wrap-around
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 6; i++) begin
        wr_en = 1'b1; data_in = 16'h0100 + 16'(pass * 6 + i);
        step();
      end
      wr_en = 1'b0;
      chk("wrap_count6", count, 6);
      for (int i = 0; i < 6; i++) begin
        rd_en = 1'b1;
        step();
        chk("wrap_order", data_out, 16'h0100 + 16'(pass * 6 + i));
      end
      rd_en = 1'b0;
    end
    chk("wrap_count0", count, 0);
    chk("wrap_empty", empty, 1);

    // Asynchronous reset between edges
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; data_in = 16'h0200 + 16'(i);
      step();
    end
    wr_en = 1'b0;
    chk("arst_pre_count", count, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_data_out", data_out, 0);
    #1 rst_n = 1'b1;
    step();
    chk("arst_after_count", count, 0);
    wr_en = 1'b1; data_in = 16'h1234;
    step();
    wr_en = 1'b0;
    chk("arst_wr_ack", wr_ack, 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("arst_readback", data_out, 16'h1234);

    // First-word-fall-through instance
    chk("fwft_rst_empty", empty2, 1);
    wr_en2 = 1'b1; data_in2 = 16'hABCD;
    step();
    wr_en2 = 1'b0;
    chk("fwft_nonempty", empty2, 0);
    chk("fwft_data", data_out2, 16'hABCD);
    rd_en2 = 1'b1;
    step();
    rd_en2 = 1'b0;
    chk("fwft_pop_empty", empty2, 1);
    wr_en2 = 1'b1; data_in2 = 16'h1111;
    step();
    data_in2 = 16'h2222;
    step();
    wr_en2 = 1'b0;
    chk("fwft_head1", data_out2, 16'h1111);
    rd_en2 = 1'b1;
    step();
    rd_en2 = 1'b0;
    chk("fwft_head2", data_out2, 16'h2222);
    chk("fwft_count", count2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
